// File: rtl/pixel_op_if.sv
// Signal bundle between pixel_op_engine and its host: start/busy/done handshake,
// operation select, source-BRAM read port and destination-BRAM write port.
interface pixel_op_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic [1:0]        op;
  logic [7:0]        param;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_dout;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_din;
  logic              dst_we;
  logic              busy;
  logic              done;

  // master is the host side (controller plus both memories); slave is the engine
  modport master (
    output start, op, param, src_dout,
    input  src_addr, dst_addr, dst_din, dst_we, busy, done
  );
  modport slave (
    input  start, op, param, src_dout,
    output src_addr, dst_addr, dst_din, dst_we, busy, done
  );
endinterface

// File: rtl/pixel_op_engine.sv
// Streams every pixel of the source image through one 8-bit point operation and
// writes the result to the same address of the destination image.
module pixel_op_engine #(
  parameter int NUM_PIXELS = 10000,
  parameter int ADDR_W     = 14,
  parameter int RD_LAT     = 1
) (
  input  logic      clk,
  input  logic      reset,
  pixel_op_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_COPY, OP_INVERT, OP_BRIGHT, OP_THRESH} op_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            r_state;
  op_t               r_op;
  logic [7:0]        r_param;
  logic [ADDR_W-1:0] r_src_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [7:0]        r_dst_din;
  logic              r_dst_we;
  logic              r_busy;
  logic              r_done;
  logic [RD_LAT-1:0] r_vld;
  logic [ADDR_W-1:0] r_adr [RD_LAT];

  logic signed [9:0] w_sum;
  logic [7:0]        w_result;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_sum    = $signed({2'b00, bus.src_dout}) + $signed({{2{r_param[7]}}, r_param});
    w_result = bus.src_dout;
    unique case (r_op)
      OP_COPY:   w_result = bus.src_dout;
      OP_INVERT: w_result = 8'd255 - bus.src_dout;
      OP_BRIGHT: begin
        if (w_sum < 10'sd0)        w_result = 8'd0;
        else if (w_sum > 10'sd255) w_result = 8'd255;
        else                       w_result = w_sum[7:0];
      end
      OP_THRESH: w_result = (bus.src_dout >= r_param) ? 8'd255 : 8'd0;
    endcase
  end

  // NOTE: the address delay line has no reset; r_vld alone qualifies each slot,
  // so clearing the valid bits is enough to flush it.
  always_ff @(posedge clk) begin
    r_adr[0] <= r_src_addr;
    for (int i = 1; i < RD_LAT; i++) r_adr[i] <= r_adr[i-1];
  end

  // NOTE: sequential state uses <= only, so each register sees pre-edge values
  // regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_COPY;
      r_param    <= '0;
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_dst_din  <= '0;
      r_dst_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_vld      <= '0;
    end else begin
      r_vld[0] <= (r_state == S_RUN);
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];

      // Result stage: address and data only move on a write, otherwise they hold.
      r_dst_we <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) begin
        r_dst_addr <= r_adr[RD_LAT-1];
        r_dst_din  <= w_result;
      end

      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_op       <= op_t'(bus.op);
            r_param    <= bus.param;
            r_busy     <= 1'b1;
            r_src_addr <= '0;
          end
        end
        S_RUN: begin
          if (r_src_addr == LAST_ADDR) begin
            r_state    <= S_DRAIN;
            r_src_addr <= '0;
          end else begin
            r_src_addr <= r_src_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // The cycle showing the final write is the last busy cycle.
          if (r_dst_we && r_dst_addr == LAST_ADDR) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.src_addr = r_src_addr;
  assign bus.dst_addr = r_dst_addr;
  assign bus.dst_din  = r_dst_din;
  assign bus.dst_we   = r_dst_we;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_pixel_op_engine.sv
// Three engines (read latency 1, 2, 3) on a shared 16-pixel source image; a
// scoreboard per engine holds expected writes, a per-engine monitor checks them.
module tb_pixel_op_engine;
  localparam int N    = 16;
  localparam int NI   = 3;
  localparam int NONE = -1000;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [1:0] op    = '0;
  logic [7:0] param = '0;
  logic [NI-1:0] start_v;
  logic [NI-1:0] we_v, busy_v, done_v;
  logic [NI-1:0][13:0] src_addr_v, dst_addr_v;
  logic [NI-1:0][7:0]  din_v;

  logic [7:0] src_mem [N];
  wr_t        exp_q [NI][$];
  int         t_start [NI];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference point operation, straight from the arithmetic definitions.
  function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] prm,
                                        input logic [7:0] p);
    int s;
    case (o)
      2'd0: return p;
      2'd1: return 8'(255 - int'(p));
      2'd2: begin
        s = int'(p) + int'($signed(prm));
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return 8'(s);
      end
      default: return (int'(p) >= int'(prm)) ? 8'd255 : 8'd0;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [7:0] pipe [LAT];

    pixel_op_if #(.ADDR_W(14)) bus ();
    assign bus.start     = start_v[g];
    assign bus.op        = op;
    assign bus.param     = param;
    assign bus.src_dout  = pipe[LAT-1];
    assign we_v[g]       = bus.dst_we;
    assign busy_v[g]     = bus.busy;
    assign done_v[g]     = bus.done;
    assign src_addr_v[g] = bus.src_addr;
    assign dst_addr_v[g] = bus.dst_addr;
    assign din_v[g]      = bus.dst_din;

    pixel_op_engine #(.NUM_PIXELS(N), .ADDR_W(14), .RD_LAT(LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    // Source BRAM with LAT cycles from address to data.
    always @(posedge clk) begin
      pipe[0] <= src_mem[bus.src_addr[3:0]];
      for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end

    always @(negedge clk) begin : mon
      int  ts;
      wr_t e;
      if (mon_on) begin
        ts = t_start[g];
        check($sformatf("lat%0d busy", LAT), bus.busy, (cyc >= ts + 1 && cyc <= ts + 1 + N + LAT));
        check($sformatf("lat%0d done", LAT), bus.done, (cyc == ts + 2 + N + LAT));
        check($sformatf("lat%0d dst_we", LAT), bus.dst_we, (cyc >= ts + 2 + LAT && cyc <= ts + 1 + N + LAT));
        check($sformatf("lat%0d src_addr", LAT), bus.src_addr,
              (cyc >= ts + 1 && cyc <= ts + N) ? cyc - ts - 1 : 0);
        if (bus.dst_we) begin
          if (exp_q[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL lat%0d write: got write to addr %0d, expected no write", LAT, bus.dst_addr);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("lat%0d dst_addr", LAT), bus.dst_addr, e.addr);
            check($sformatf("lat%0d dst_din @%0d", LAT, e.addr), bus.dst_din, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input int i);
    wr_t w;
    t_start[i] = cyc;
    for (int k = 0; k < N; k++) begin
      w.addr = 14'(k);
      w.data = ref_op(op, param, src_mem[k]);
      exp_q[i].push_back(w);
    end
  endtask

  task automatic check_drained();
    for (int i = 0; i < NI; i++)
      check($sformatf("lat%0d pending writes", i + 1), exp_q[i].size(), 0);
  endtask

  task automatic run_pass(input logic [NI-1:0] mask);
    for (int i = 0; i < NI; i++) if (mask[i]) push_pass(i);
    start_v = mask;
    step();
    start_v = '0;
    repeat (N + 6) step();
    check_drained();
  endtask

  task automatic rand_image();
    for (int k = 0; k < N; k++) src_mem[k] = 8'($urandom);
  endtask

  initial begin
    int n;
    int seen;
    start_v = '0;
    for (int i = 0; i < NI; i++) t_start[i] = NONE;
    for (int k = 0; k < N; k++) src_mem[k] = '0;

    reset = 1'b1;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      check("reset src_addr", src_addr_v[i], 0);
      check("reset dst_addr", dst_addr_v[i], 0);
      check("reset dst_din", din_v[i], 0);
      check("reset dst_we", we_v[i], 0);
      check("reset busy", busy_v[i], 0);
      check("reset done", done_v[i], 0);
    end
    reset = 1'b0;
    mon_on = 1'b1;
    step();

    // Invert a ramp
    for (int k = 0; k < N; k++) src_mem[k] = 8'(k * 16);
    op = 2'd1; param = 8'd0;
    run_pass('1);

    // Brightness saturation both ways
    rand_image();
    src_mem[0] = 8'd250; src_mem[1] = 8'd5; src_mem[2] = 8'd100; src_mem[3] = 8'd0;
    op = 2'd2; param = 8'h0A;
    run_pass('1);
    param = 8'hF6;
    run_pass('1);

    // Threshold around the level
    rand_image();
    src_mem[0] = 8'd0; src_mem[1] = 8'd127; src_mem[2] = 8'd128; src_mem[3] = 8'd255;
    op = 2'd3; param = 8'd128;
    run_pass('1);

    // Copy, then random operations
    rand_image();
    op = 2'd0; param = 8'($urandom);
    run_pass('1);
    repeat (4) begin
      rand_image();
      op = 2'($urandom); param = 8'($urandom);
      run_pass('1);
    end

    // Re-start and new op/param mid-pass must not disturb the latched pass
    rand_image();
    op = 2'd1; param = 8'($urandom);
    for (int i = 0; i < NI; i++) push_pass(i);
    start_v = '1;
    step();
    start_v = '0;
    repeat (4) step();
    op = 2'd2; param = 8'h7F;
    start_v = '1;
    step();
    start_v = '0;
    repeat (N + 6) step();
    check_drained();

    // start in the DONE cycle is ignored; held into the next (IDLE) cycle it is taken
    for (int i = 0; i < NI; i++) begin
      rand_image();
      op = 2'($urandom); param = 8'($urandom);
      push_pass(i);
      start_v[i] = 1'b1;
      step();
      start_v[i] = 1'b0;
      n = 0;
      while (!done_v[i] && n < 100) begin
        step();
        n++;
      end
      check($sformatf("lat%0d done reached", i + 1), done_v[i], 1);
      start_v[i] = 1'b1;
      step();
      push_pass(i);
      step();
      start_v[i] = 1'b0;
      repeat (N + 6) step();
      check_drained();
    end

    // Reset right after the 5th write of a pass
    rand_image();
    op = 2'($urandom); param = 8'($urandom);
    for (int i = 0; i < NI; i++) push_pass(i);
    start_v = '1;
    step();
    start_v = '0;
    n = 0; seen = 0;
    while (n < 100) begin
      if (we_v[0]) seen++;
      if (seen == 5) break;
      step();
      n++;
    end
    check("fifth write reached", seen, 5);
    reset = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      t_start[i] = NONE;
      exp_q[i].delete();
    end
    check("mid-pass reset dst_we", we_v, 0);
    check("mid-pass reset busy", busy_v, 0);
    check("mid-pass reset dst_addr", dst_addr_v, 0);
    reset = 1'b0;
    repeat (N + 8) step();
    run_pass('1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pixel_op_engine.md
# pixel_op_engine

Point-processing stage between the original-image memory and the processed-image memory. Once UART image reception completes, it streams every pixel out of the original-image block RAM, applies one selectable 8-bit point operation, and writes the result at the same address in the processed-image block RAM. It provides a start/busy/done handshake so later stages, such as UART transmit-back or display, can chain on completion.

## Interface

Parameters:
- NUM_PIXELS, 10000: pixels per image (100x100); addresses 0..NUM_PIXELS-1.
- ADDR_W, 14: address width of both memories.
- RD_LAT, 1: source BRAM read latency in cycles (address to dout); legal values 1..3.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one pass; sampled only in IDLE; intended to be driven from ImRxComplete.
- op  in  2  operation select: 00 copy, 01 invert, 10 brightness, 11 threshold.
- param  in  8  operand: signed offset for brightness, unsigned level for threshold.
- src_addr  out  ADDR_W  read address to the original-image BRAM.
- src_dout  in  8  read data from the original-image BRAM.
- dst_addr  out  ADDR_W  write address to the processed-image BRAM.
- dst_din  out  8  write data.
- dst_we  out  1  write enable, one pixel per asserted cycle.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of a completed pass.

## Operation

- States:
  - IDLE -> RUN when start=1.
  - RUN issues reads; after the last read address it moves to DRAIN.
  - DRAIN waits for in-flight results to be written; after the last write it moves to DONE.
  - DONE lasts one cycle, then returns to IDLE.
- op and param are latched on the accepting start. Later changes have no effect until the next pass.
- start is ignored in RUN, DRAIN and DONE. It is not queued.
- Read counter: runs 0..NUM_PIXELS-1, one address per RUN cycle, with no wrap.
- A delay line of depth RD_LAT tracks the valid flag and address alongside the returning data.
- Arithmetic, with p = src_dout:
  - Copy: out = p.
  - Invert: out = 255 - p.
  - Brightness: out = clamp(p + sign_extend(param), 0, 255). Compute at 10 bits signed, then saturate.
  - Threshold: out = (p >= param) ? 255 : 0.
- Result stage is registered. dst_addr equals the source address of the same pixel.
- Exactly NUM_PIXELS writes per pass, in ascending address order, with no gaps.

## Timing

- Reset values: src_addr=0, dst_addr=0, dst_din=0, dst_we=0, busy=0, done=0; state IDLE; latched op/param = 0.
- Let start be sampled high in IDLE at cycle T:
  - Reads: src_addr=k in cycle T+1+k, for k=0..NUM_PIXELS-1.
  - Data: src_dout for address k is consumed in cycle T+1+k+RD_LAT.
  - Writes: dst_we=1, dst_addr=k in cycle T+2+k+RD_LAT.
  - Last write: cycle T+1+NUM_PIXELS+RD_LAT.
  - done=1 only in cycle T+2+NUM_PIXELS+RD_LAT.
  - busy=1 from cycle T+1 through the last-write cycle. busy=0 while done=1.
- Total pass latency is NUM_PIXELS+RD_LAT+2 cycles from start to done.
- Outside RUN, src_addr holds 0. When dst_we=0, dst_addr and dst_din hold their last values.
- A start asserted in the DONE cycle is ignored. A start in the following cycle (IDLE) is accepted.
- Reset mid-pass: in the cycle after reset is sampled, all outputs are at reset values. No further writes are issued and no done pulse occurs. A later start performs a full pass from address 0.
- start and reset high in the same cycle: reset wins.

## Test plan

- Invert, NUM_PIXELS=16, RD_LAT=1, source p[k]=k*16:
  - Destination holds 255-16k for all k.
  - The first write occurs 3 cycles after start.
  - done occurs exactly 19 cycles after start.
  - Exactly 16 dst_we cycles.
- Brightness saturation, NUM_PIXELS=4, source {250, 5, 100, 0}:
  - param=+10 (0x0A) -> {255, 15, 110, 10}.
  - param=-10 (0xF6) -> {240, 0, 90, 0}.
- Threshold, param=128, source {0, 127, 128, 255} -> {0, 0, 255, 255}.
- Copy with RD_LAT=2 and RD_LAT=3:
  - Destination equals source.
  - First write lands at T+4 and T+5 respectively.
- Handshake:
  - Pulse start again mid-pass, and change op/param mid-pass -> no restart, results use the latched op, a single done pulse.
  - start in the DONE cycle is ignored; start one cycle later begins a new pass.
- Reset after the 5th write of a 16-pixel pass:
  - Next cycle: dst_we=0, busy=0, done never pulses.
  - A following start rewrites all 16 addresses correctly.
